// File: rtl/ddr_req_queue_pkg.sv
// ddr_package: shared types and defaults for the DDR request queue.
//   req_entry_t  - request word {rw, addr, data} handed to the controller
//   req_state_e  - issue FSM states
//   REQ_ADDR_W / REQ_DATA_W fix the struct field widths; DEF_DEPTH and
//   DEF_BUSY_TO are the default parameter values.
package ddr_package;
  localparam int REQ_ADDR_W  = 32;
  localparam int REQ_DATA_W  = 64;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_BUSY_TO = 16;

  typedef struct packed {
    logic                  rw;   // 1 = write, 0 = read
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} req_state_e;
endpackage

// File: rtl/ddr_req_fifo.sv
// ddr_req_fifo: in-order request storage.
//   clock, reset      - rising edge, synchronous active-high reset
//   push / wr_entry   - write wr_entry at the tail
//   pop  / rd_entry   - rd_entry is the head (combinational); pop advances it
//   full, empty       - derived from count only
//   count             - occupancy, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap on their own (DEPTH is a power of 2).
module ddr_req_fifo
  import ddr_package::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  req_entry_t               wr_entry,
  output req_entry_t               rd_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // both or neither: occupancy unchanged
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/ddr_req_queue.sv
// ddr_req_queue: host request buffer in front of the DDR controller.
//   clock, reset            - rising edge, synchronous active-high reset
//   req_valid/req_ready     - host handshake; req_ready = not full
//   req_write/addr/data     - request fields (data ignored for reads)
//   data_out, act_cmd       - issued request word, qualified by a 1-cycle pulse
//   dev_busy                - controller busy; gates launch and closes an issue
//   q_count                 - queue occupancy
//   issue_err               - sticky: dev_busy failed to rise within BUSY_TO
// Optional: define DDR_REQ_STATS_EN to add wr_issued / rd_issued counters.
// Struct field widths come from ddr_package; ADDR_W/DATA_W size the host ports.
module ddr_req_queue
  import ddr_package::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = REQ_ADDR_W,
  parameter int DATA_W  = REQ_DATA_W,
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  output req_entry_t             data_out,
  output logic                   act_cmd,
  input  logic                   dev_busy,
  output logic [$clog2(DEPTH):0] q_count,
`ifdef DDR_REQ_STATS_EN
  output logic [31:0]            wr_issued,
  output logic [31:0]            rd_issued,
`endif
  output logic                   issue_err
);
  localparam int TW = $clog2(BUSY_TO + 1);

  req_state_e  state;
  logic [TW-1:0] to_cnt;
  req_entry_t  wr_entry, head;
  logic        push, launch, full, empty;

  assign wr_entry  = '{rw: req_write, addr: req_addr, data: req_data};
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  // Launch reads the registered count, so an entry pushed this cycle waits one.
  assign launch    = (state == IDLE) && !empty && !dev_busy;

  ddr_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (launch),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (q_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      act_cmd   <= 1'b0;
      data_out  <= '0;
      to_cnt    <= '0;
      issue_err <= 1'b0;
    end else begin
      act_cmd <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          data_out <= head;
          act_cmd  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          state  <= WAIT_BUSY;
          to_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (dev_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TW'(BUSY_TO - 1)) begin
            issue_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: if (!dev_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef DDR_REQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_issued <= '0;
      rd_issued <= '0;
    end else if (state == ISSUE) begin
      if (data_out.rw && (wr_issued != 32'hFFFF_FFFF))  wr_issued <= wr_issued + 1'b1;
      if (!data_out.rw && (rd_issued != 32'hFFFF_FFFF)) rd_issued <= rd_issued + 1'b1;
    end
  end
`endif
endmodule
